// File: rtl/argon_alu.sv
// argon_alu: bus-attached multi-cycle 16-bit ALU with operand latches, iterative shifts
// and an optional iterative multiply (opcode 10) enabled by defining ARGON_ALU_MUL_EN.
module argon_alu (
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic [15:0] i_bus,
    input  logic        i_latchA,
    input  logic        i_latchB,
    input  logic        i_start,
    input  logic [3:0]  i_op,
    input  logic        i_outputResult,
    output logic [15:0] o_bus,
    output logic        o_bus_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_flags
);

    localparam int unsigned W  = 16;
    localparam int unsigned FW = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned KW = 2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ASR  = 4'd8;
    localparam logic [3:0] OP_PASS = 4'd9;
`ifdef ARGON_ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd10;
`endif

    localparam logic [KW-1:0] K_SHL = 2'd0;
    localparam logic [KW-1:0] K_SHR = 2'd1;
    localparam logic [KW-1:0] K_ASR = 2'd2;

`ifdef ARGON_ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2, S_MUL = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
`endif

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [W-1:0]   result_q, result_d;
    logic [FW-1:0]  flags_q, flags_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [KW-1:0]  kind_q, kind_d;
`ifdef ARGON_ALU_MUL_EN
    logic [W-1:0]   acc_q, acc_d, mplier_q, mplier_d;
    logic [W-1:0]   acc_n;
`endif

    logic           busy_c;
    logic           finish;
    logic [W:0]     sum;
    logic [W:0]     step;
    logic [W-1:0]   res;
    logic           c_flag;
    logic           v_flag;
    logic [KW-1:0]  kind_sel;

    // One-bit shift step: returns {bit shifted out, shifted value}
    function automatic logic [W:0] shift1(input logic [KW-1:0] kind, input logic [W-1:0] v);
        logic [W:0] r;
        case (kind)
            K_SHL:   r = {v[W-1], v[W-2:0], 1'b0};
            K_SHR:   r = {v[0], 1'b0, v[W-1:1]};
            default: r = {v[0], v[W-1], v[W-1:1]};
        endcase
        return r;
    endfunction

`ifdef ARGON_ALU_MUL_EN
    assign busy_c = (state_q == S_SHIFT) || (state_q == S_MUL);
`else
    assign busy_c = (state_q == S_SHIFT);
`endif

    assign o_busy      = busy_c;
    assign o_done      = (state_q == S_DONE);
    assign o_flags     = flags_q;
    assign o_bus_valid = i_outputResult & ~busy_c;
    assign o_bus       = o_bus_valid ? result_q : 16'h0000;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flags_d  = flags_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        kind_d   = kind_q;
`ifdef ARGON_ALU_MUL_EN
        acc_d    = acc_q;
        mplier_d = mplier_q;
        acc_n    = '0;
`endif
        finish   = 1'b0;
        sum      = '0;
        step     = '0;
        res      = '0;
        c_flag   = 1'b0;
        v_flag   = 1'b0;
        kind_sel = kind_q;

        // Operands are frozen while an iterative op is running
        if (!busy_c) begin
            if (i_latchA) a_d = i_bus;
            if (i_latchB) b_d = i_bus;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (i_start) begin
                    finish = 1'b1;
                    case (i_op)
                        OP_ADD: begin
                            sum    = {1'b0, a_q} + {1'b0, b_q};
                            res    = sum[W-1:0];
                            c_flag = sum[W];
                            v_flag = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
                        end
                        OP_SUB: begin
                            sum    = {1'b0, a_q} - {1'b0, b_q};
                            res    = sum[W-1:0];
                            c_flag = sum[W];
                            v_flag = (a_q[W-1] != b_q[W-1]) && (sum[W-1] != a_q[W-1]);
                        end
                        OP_AND:  res = a_q & b_q;
                        OP_OR:   res = a_q | b_q;
                        OP_XOR:  res = a_q ^ b_q;
                        OP_NOT:  res = ~a_q;
                        OP_PASS: res = b_q;
                        OP_SHL, OP_SHR, OP_ASR: begin
                            kind_sel = (i_op == OP_SHL) ? K_SHL :
                                       (i_op == OP_SHR) ? K_SHR : K_ASR;
                            step = shift1(kind_sel, a_q);
                            if (b_q[3:0] == 4'd0) begin
                                res = a_q;
                            end else if (b_q[3:0] == 4'd1) begin
                                res    = step[W-1:0];
                                c_flag = step[W];
                            end else begin
                                // First bit shifts now; remaining k-1 bits in SHIFT
                                finish  = 1'b0;
                                sh_d    = step[W-1:0];
                                cnt_d   = b_q[3:0] - 4'd1;
                                kind_d  = kind_sel;
                                state_d = S_SHIFT;
                            end
                        end
`ifdef ARGON_ALU_MUL_EN
                        OP_MUL: begin
                            finish   = 1'b0;
                            acc_d    = '0;
                            sh_d     = a_q;
                            mplier_d = b_q;
                            cnt_d    = '0;
                            state_d  = S_MUL;
                        end
`endif
                        default: res = '0;
                    endcase
                end
            end
            S_SHIFT: begin
                step  = shift1(kind_q, sh_q);
                sh_d  = step[W-1:0];
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    finish = 1'b1;
                    res    = step[W-1:0];
                    c_flag = step[W];
                end
            end
`ifdef ARGON_ALU_MUL_EN
            // Shift-add: sh_q holds the shifted multiplicand, mplier_q the remaining multiplier
            S_MUL: begin
                acc_n    = acc_q + (mplier_q[0] ? sh_q : 16'h0000);
                acc_d    = acc_n;
                sh_d     = {sh_q[W-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[W-1:1]};
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    finish = 1'b1;
                    res    = acc_n;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            result_d = res;
            flags_d  = {(res == 16'h0000), res[W-1], c_flag, v_flag};
            state_d  = S_DONE;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            kind_q   <= K_SHL;
`ifdef ARGON_ALU_MUL_EN
            acc_q    <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            kind_q   <= kind_d;
`ifdef ARGON_ALU_MUL_EN
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
`endif
        end
    end

endmodule

// File: tb/tb_argon_alu.sv
// Directed self-checking bench for argon_alu (default build or with ARGON_ALU_MUL_EN).
module tb_argon_alu;

    logic        i_Clk;
    logic        i_Reset_n;
    logic [15:0] i_bus;
    logic        i_latchA;
    logic        i_latchB;
    logic        i_start;
    logic [3:0]  i_op;
    logic        i_outputResult;
    logic [15:0] o_bus;
    logic        o_bus_valid;
    logic        o_busy;
    logic        o_done;
    logic [3:0]  o_flags;

    int n_checks;
    int n_fail;

    argon_alu dut (
        .i_Clk          (i_Clk),
        .i_Reset_n      (i_Reset_n),
        .i_bus          (i_bus),
        .i_latchA       (i_latchA),
        .i_latchB       (i_latchB),
        .i_start        (i_start),
        .i_op           (i_op),
        .i_outputResult (i_outputResult),
        .o_bus          (o_bus),
        .o_bus_valid    (o_bus_valid),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_flags        (o_flags)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic load_ab(input logic [15:0] a, input logic [15:0] b);
        i_bus = a; i_latchA = 1'b1;
        tick();
        i_latchA = 1'b0; i_bus = b; i_latchB = 1'b1;
        tick();
        i_latchB = 1'b0; i_bus = 16'h0000;
    endtask

    task automatic issue(input logic [3:0] op);
        i_op = op; i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        i_Reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: busy=%b done=%b expected 0 0", o_busy, o_done);
        end
        n_checks++;
        if (o_flags !== 4'h0) begin
            n_fail++; $display("FAIL reset_flags: got %h expected 0", o_flags);
        end
        n_checks++;
        if (o_bus_valid !== 1'b1 || o_bus !== 16'h0000) begin
            n_fail++; $display("FAIL reset_bus: valid=%b bus=%h expected 1 0000", o_bus_valid, o_bus);
        end
        i_Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_add_sub();
        load_ab(16'h7FFF, 16'h0001);
        issue(4'd0);
        n_checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL add_done: done=%b busy=%b expected 1 0", o_done, o_busy);
        end
        n_checks++;
        if (o_bus !== 16'h8000 || o_flags !== 4'b0101) begin
            n_fail++; $display("FAIL add_result: bus=%h flags=%b expected 8000 0101", o_bus, o_flags);
        end
        tick();
        n_checks++;
        if (o_done !== 1'b0 || o_bus !== 16'h8000) begin
            n_fail++; $display("FAIL add_hold: done=%b bus=%h expected 0 8000", o_done, o_bus);
        end
        load_ab(16'h0003, 16'h0005);
        issue(4'd1);
        n_checks++;
        if (o_bus !== 16'hFFFE || o_flags !== 4'b0110) begin
            n_fail++; $display("FAIL sub_result: bus=%h flags=%b expected fffe 0110", o_bus, o_flags);
        end
    endtask

    task automatic test_logic();
        load_ab(16'hF0F0, 16'hFF00);
        issue(4'd2);
        n_checks++;
        if (o_bus !== 16'hF000 || o_flags !== 4'b0100) begin
            n_fail++; $display("FAIL and_result: bus=%h flags=%b expected f000 0100", o_bus, o_flags);
        end
        issue(4'd3);
        n_checks++;
        if (o_bus !== 16'hFFF0 || o_flags !== 4'b0100) begin
            n_fail++; $display("FAIL or_result: bus=%h flags=%b expected fff0 0100", o_bus, o_flags);
        end
        issue(4'd4);
        n_checks++;
        if (o_bus !== 16'h0FF0 || o_flags !== 4'b0000) begin
            n_fail++; $display("FAIL xor_result: bus=%h flags=%b expected 0ff0 0000", o_bus, o_flags);
        end
        issue(4'd5);
        n_checks++;
        if (o_bus !== 16'h0F0F || o_flags !== 4'b0000) begin
            n_fail++; $display("FAIL not_result: bus=%h flags=%b expected 0f0f 0000", o_bus, o_flags);
        end
        issue(4'd9);
        n_checks++;
        if (o_bus !== 16'hFF00 || o_flags !== 4'b0100) begin
            n_fail++; $display("FAIL pass_result: bus=%h flags=%b expected ff00 0100", o_bus, o_flags);
        end
        load_ab(16'h0F0F, 16'hF0F0);
        issue(4'd2);
        n_checks++;
        if (o_bus !== 16'h0000 || o_flags !== 4'b1000) begin
            n_fail++; $display("FAIL and_zero: bus=%h flags=%b expected 0000 1000", o_bus, o_flags);
        end
    endtask

    task automatic test_shift();
        load_ab(16'h8010, 16'h0004);
        issue(4'd8);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (o_busy !== 1'b1 || o_done !== 1'b0 || o_bus_valid !== 1'b0 || o_bus !== 16'h0000) begin
                n_fail++;
                $display("FAIL asr_busy%0d: busy=%b done=%b valid=%b bus=%h expected 1 0 0 0000",
                         i, o_busy, o_done, o_bus_valid, o_bus);
            end
            tick();
        end
        n_checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_bus !== 16'hF801 || o_flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL asr_result: done=%b busy=%b bus=%h flags=%b expected 1 0 f801 0100",
                     o_done, o_busy, o_bus, o_flags);
        end
        load_ab(16'h1234, 16'h0000);
        issue(4'd6);
        n_checks++;
        if (o_done !== 1'b1 || o_bus !== 16'h1234 || o_flags !== 4'b0000) begin
            n_fail++; $display("FAIL shl0_result: done=%b bus=%h flags=%b expected 1 1234 0000", o_done, o_bus, o_flags);
        end
        load_ab(16'h0003, 16'h0001);
        issue(4'd7);
        n_checks++;
        if (o_done !== 1'b1 || o_bus !== 16'h0001 || o_flags !== 4'b0010) begin
            n_fail++; $display("FAIL shr1_result: done=%b bus=%h flags=%b expected 1 0001 0010", o_done, o_bus, o_flags);
        end
        load_ab(16'hC001, 16'hFFF2);
        issue(4'd6);
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++; $display("FAIL shl2_busy: busy=%b expected 1", o_busy);
        end
        tick();
        n_checks++;
        if (o_done !== 1'b1 || o_bus !== 16'h0004 || o_flags !== 4'b0010) begin
            n_fail++; $display("FAIL shl2_result: done=%b bus=%h flags=%b expected 1 0004 0010", o_done, o_bus, o_flags);
        end
    endtask

    task automatic test_back_to_back();
        load_ab(16'h00F0, 16'h0003);
        issue(4'd7);
        i_bus = 16'hFFFF; i_latchA = 1'b1; i_latchB = 1'b1; i_op = 4'd0; i_start = 1'b1;
        tick();
        i_latchA = 1'b0; i_latchB = 1'b0; i_start = 1'b0; i_bus = 16'h0000;
        n_checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            n_fail++; $display("FAIL busy_ignore: busy=%b done=%b expected 1 0", o_busy, o_done);
        end
        tick();
        n_checks++;
        if (o_done !== 1'b1 || o_bus !== 16'h001E || o_flags !== 4'b0000) begin
            n_fail++; $display("FAIL shr3_result: done=%b bus=%h flags=%b expected 1 001e 0000", o_done, o_bus, o_flags);
        end
        issue(4'd5);
        n_checks++;
        if (o_done !== 1'b1 || o_bus !== 16'hFF0F || o_flags !== 4'b0100) begin
            n_fail++; $display("FAIL done_start: done=%b bus=%h flags=%b expected 1 ff0f 0100", o_done, o_bus, o_flags);
        end
    endtask

    task automatic test_same_cycle();
        load_ab(16'h0000, 16'h00FF);
        i_bus = 16'h1234; i_latchA = 1'b1; i_op = 4'd9; i_start = 1'b1;
        tick();
        i_latchA = 1'b0; i_start = 1'b0; i_bus = 16'h0000;
        n_checks++;
        if (o_bus !== 16'h00FF || o_flags !== 4'b0000) begin
            n_fail++; $display("FAIL same_pass: bus=%h flags=%b expected 00ff 0000", o_bus, o_flags);
        end
        issue(4'd5);
        n_checks++;
        if (o_bus !== 16'hEDCB || o_flags !== 4'b0100) begin
            n_fail++; $display("FAIL same_not: bus=%h flags=%b expected edcb 0100", o_bus, o_flags);
        end
    endtask

    task automatic test_undef_mul();
        issue(4'd11);
        n_checks++;
        if (o_done !== 1'b1 || o_bus !== 16'h0000 || o_flags !== 4'b1000) begin
            n_fail++; $display("FAIL undef_result: done=%b bus=%h flags=%b expected 1 0000 1000", o_done, o_bus, o_flags);
        end
        load_ab(16'h0123, 16'h0100);
        issue(4'd10);
`ifdef ARGON_ALU_MUL_EN
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (o_busy !== 1'b1 || o_done !== 1'b0) begin
                n_fail++; $display("FAIL mul_busy%0d: busy=%b done=%b expected 1 0", i, o_busy, o_done);
            end
            tick();
        end
        n_checks++;
        if (o_done !== 1'b1 || o_bus !== 16'h2300 || o_flags !== 4'b0000) begin
            n_fail++; $display("FAIL mul_result: done=%b bus=%h flags=%b expected 1 2300 0000", o_done, o_bus, o_flags);
        end
`else
        n_checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_bus !== 16'h0000 || o_flags !== 4'b1000) begin
            n_fail++;
            $display("FAIL op10_undef: done=%b busy=%b bus=%h flags=%b expected 1 0 0000 1000",
                     o_done, o_busy, o_bus, o_flags);
        end
`endif
    endtask

    task automatic test_reset_mid();
        load_ab(16'h0001, 16'h0001);
        issue(4'd9);
        load_ab(16'h0001, 16'h000F);
        issue(4'd6);
        tick();
        tick();
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_busy: busy=%b expected 1", o_busy);
        end
        i_Reset_n = 1'b0;
        #1;
        n_checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_flags !== 4'h0) begin
            n_fail++; $display("FAIL mid_reset: busy=%b done=%b flags=%h expected 0 0 0", o_busy, o_done, o_flags);
        end
        n_checks++;
        if (o_bus_valid !== 1'b1 || o_bus !== 16'h0000) begin
            n_fail++; $display("FAIL mid_bus: valid=%b bus=%h expected 1 0000", o_bus_valid, o_bus);
        end
        tick();
        i_Reset_n = 1'b1;
        tick();
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_discard: done=%b busy=%b expected 0 0", o_done, o_busy);
        end
        issue(4'd5);
        n_checks++;
        if (o_bus !== 16'hFFFF || o_flags !== 4'b0100) begin
            n_fail++; $display("FAIL mid_a_cleared: bus=%h flags=%b expected ffff 0100", o_bus, o_flags);
        end
        issue(4'd9);
        n_checks++;
        if (o_bus !== 16'h0000 || o_flags !== 4'b1000) begin
            n_fail++; $display("FAIL mid_b_cleared: bus=%h flags=%b expected 0000 1000", o_bus, o_flags);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        i_Reset_n = 1'b0;
        i_bus = 16'h0000;
        i_latchA = 1'b0;
        i_latchB = 1'b0;
        i_start = 1'b0;
        i_op = 4'd0;
        i_outputResult = 1'b1;
        #2;
        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_back_to_back();
        test_same_cycle();
        test_undef_mul();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
